// File: rtl/matrix_operand_loader_pkg.sv
// Shared definitions for the matrix-multiply operand path.
// Holds the matrix geometry, the loader FSM state encoding and the
// row-major to column-major address transpose used by the loader and by
// the result-readback stage.
package matrix_operand_loader_pkg;

    localparam int unsigned N      = 8;   // matrix dimension
    localparam int unsigned DATA_W = 8;   // signed operand width
    localparam int unsigned ADDR_W = 6;   // operand RAM address width
    localparam int unsigned C_W    = 19;  // result element width

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_START  = 3'd5,
        ST_WAIT   = 3'd6
    } state_t;

    // Row-major index r*8+c -> column-major address c*8+r.
    function automatic logic [ADDR_W-1:0] transpose_addr(input logic [ADDR_W-1:0] idx);
        return {idx[2:0], idx[5:3]};
    endfunction

endpackage

// File: rtl/matrix_operand_loader_write_port.sv
// operand_write_port: registered RAM write stage for one operand matrix.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   wr_en         - element accepted for this matrix this cycle
//   idx           - row-major element index of the accepted element
//   data          - accepted element
//   mwr/addr/mdi  - RAM strobe, transposed address and data, one cycle later
// Address and data hold their last values while no write is issued.
module operand_write_port
    import matrix_operand_loader_pkg::*;
#(
    parameter int unsigned DATA_W = matrix_operand_loader_pkg::DATA_W,
    parameter int unsigned ADDR_W = matrix_operand_loader_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] data,
    output logic              mwr,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] mdi
);

    always_ff @(posedge clk) begin
        if (reset) begin
            mwr  <= 1'b0;
            addr <= '0;
            mdi  <= '0;
        end else begin
            mwr <= wr_en;
            if (wr_en) begin
                addr <= transpose_addr(idx);
                mdi  <= data;
            end
        end
    end

endmodule

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: streams A then B (row-major, 64 bytes each) into
// the column-major operand RAMs, then clears, starts and waits for the
// multiply engine.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   load_req                - begin a new load (honoured in IDLE only)
//   in_valid/in_data/in_ready - element stream handshake
//   a_mwr/a_addr/a_mdi      - A operand RAM write port
//   b_mwr/b_addr/b_mdi      - B operand RAM write port
//   mult_reset, mult_start  - one-cycle engine control pulses
//   mult_done               - engine done level
//   busy                    - load/multiply in progress
//   elem_count              - elements accepted in the current matrix
//   load_complete           - one-cycle pulse when the engine finishes
module matrix_operand_loader
    import matrix_operand_loader_pkg::*;
#(
    parameter int unsigned N      = matrix_operand_loader_pkg::N,
    parameter int unsigned DATA_W = matrix_operand_loader_pkg::DATA_W,
    parameter int unsigned ADDR_W = matrix_operand_loader_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              a_mwr,
    output logic [ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0] a_mdi,
    output logic              b_mwr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_mdi,
    output logic              mult_reset,
    output logic              mult_start,
    input  logic              mult_done,
    output logic              busy,
    output logic [ADDR_W-1:0] elem_count,
    output logic              load_complete
);

    state_t state, state_nxt;
    logic   accept;
    logic   last_elem;

    assign accept    = in_valid & in_ready;
    assign last_elem = (elem_count == ADDR_W'(N * N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        in_ready      = 1'b0;
        mult_reset    = 1'b0;
        mult_start    = 1'b0;
        load_complete = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_req) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                mult_reset = 1'b1;
                state_nxt  = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid && last_elem) state_nxt = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid && last_elem) state_nxt = ST_FLUSH;
            end
            // Last B strobe is on the RAM port during this cycle.
            ST_FLUSH: begin
                state_nxt = ST_START;
            end
            ST_START: begin
                mult_start = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (mult_done) begin
                    load_complete = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // elem_count wraps 63 -> 0 at the A/B boundary without extra logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= 1'b0;
            elem_count <= '0;
        end else begin
            if (state == ST_IDLE && load_req) busy <= 1'b1;
            if (state == ST_WAIT && mult_done) busy <= 1'b0;
            if (state == ST_CLEAR) begin
                elem_count <= '0;
            end else if (accept) begin
                elem_count <= elem_count + ADDR_W'(1);
            end
        end
    end

    operand_write_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
        .clk   (clk),
        .reset (reset),
        .wr_en (accept && (state == ST_LOAD_A)),
        .idx   (elem_count),
        .data  (in_data),
        .mwr   (a_mwr),
        .addr  (a_addr),
        .mdi   (a_mdi)
    );

    operand_write_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
        .clk   (clk),
        .reset (reset),
        .wr_en (accept && (state == ST_LOAD_B)),
        .idx   (elem_count),
        .data  (in_data),
        .mwr   (b_mwr),
        .addr  (b_addr),
        .mdi   (b_mdi)
    );

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboard bench for matrix_operand_loader: the driver pushes the expected
// RAM write for every accepted element; a monitor thread pops and compares
// on every a_mwr/b_mwr strobe and counts engine control pulses.
module tb_matrix_operand_loader;

    logic       clk = 1'b0;
    logic       reset, load_req, in_valid, mult_done;
    logic [7:0] in_data;
    logic       in_ready, a_mwr, b_mwr, mult_reset, mult_start, busy, load_complete;
    logic [5:0] a_addr, b_addr, elem_count;
    logic [7:0] a_mdi, b_mdi;

    always #5 clk = ~clk;

    matrix_operand_loader #(.N(8), .DATA_W(8), .ADDR_W(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_req      (load_req),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .a_mwr         (a_mwr),
        .a_addr        (a_addr),
        .a_mdi         (a_mdi),
        .b_mwr         (b_mwr),
        .b_addr        (b_addr),
        .b_mdi         (b_mdi),
        .mult_reset    (mult_reset),
        .mult_start    (mult_start),
        .mult_done     (mult_done),
        .busy          (busy),
        .elem_count    (elem_count),
        .load_complete (load_complete)
    );

    typedef struct {
        bit         is_b;
        logic [5:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int a_strobes = 0, b_strobes = 0, n_start = 0, n_mreset = 0, n_lc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] elem_val(input int mode, input int idx);
        if (mode == 1) return (idx < 64) ? 8'sd0 - 8'sd128 : 8'sd127;
        return 8'(idx % 128);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctrl"},
              {a_mwr, b_mwr, mult_reset, mult_start, busy, load_complete, in_ready, elem_count}, '0);
        check({tag, "_data"}, {a_addr, b_addr, a_mdi, b_mdi}, '0);
    endtask

    // Issue load_req and stream elements until 'stop' accepts.
    task automatic run_load(input int mode, input bit gap, input bit poke, input int stop);
        int idx = 0;
        int cyc = 0;
        int e;
        exp_t x;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check("clear_mult_reset", mult_reset, 1);
        check("clear_busy", busy, 1);
        check("clear_no_write", {a_mwr, b_mwr}, 0);
        mult_done = 1'b0;
        tick();
        while (idx < stop && cyc < 600) begin
            check("elem_count", elem_count, idx % 64);
            mult_done = poke && idx >= 10 && idx < 14;
            load_req  = poke && idx == 80;
            in_valid  = gap ? (cyc % 2 == 0) : 1'b1;
            in_data   = elem_val(mode, idx);
            if (in_valid && in_ready) begin
                e      = idx % 64;
                x.is_b = (idx >= 64);
                x.addr = 6'((e % 8) * 8 + e / 8);
                x.data = in_data;
                sb.push_back(x);
                idx++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        mult_done = 1'b0;
        load_req  = 1'b0;
        if (idx < stop) check("stream_timeout", idx, stop);
        if (stop == 128) begin
            check("flush_in_ready", in_ready, 0);
            check("flush_no_start", mult_start, 0);
            tick();
            check("start_pulse", mult_start, 1);
            tick();
            check("start_one_cycle", mult_start, 0);
            check("wait_busy", busy, 1);
        end
    endtask

    task automatic finish_wait(input int delay, input int lc0);
        repeat (delay) tick();
        check("wait_no_complete", load_complete, 0);
        mult_done = 1'b1;
        #1;
        check("done_pulse", load_complete, 1);
        tick();
        check("busy_fall", busy, 0);
        check("complete_one_cycle", load_complete, 0);
        check("complete_count", n_lc, lc0 + 1);
    endtask

    initial begin
        int a0, b0, s0, r0, l0;
        exp_t x;

        fork
            forever begin
                @(negedge clk);
                if (mult_start) n_start++;
                if (mult_reset) n_mreset++;
                if (load_complete) n_lc++;
                if (a_mwr || b_mwr) begin
                    check("mwr_exclusive", a_mwr & b_mwr, 0);
                    if (a_mwr) a_strobes++;
                    if (b_mwr) b_strobes++;
                    if (sb.size() == 0) begin
                        check("spurious_strobe", {a_mwr, b_mwr}, 0);
                    end else begin
                        x = sb.pop_front();
                        check("strobe_matrix", b_mwr, x.is_b);
                        check("strobe_addr", b_mwr ? b_addr : a_addr, x.addr);
                        check("strobe_data", b_mwr ? b_mdi : a_mdi, x.data);
                    end
                end
            end
        join_none

        reset = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = '0; mult_done = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset_state");
        reset = 1'b0;
        tick();
        check_idle_outputs("post_reset");

        // Back-to-back index stream, done 50 cycles after start.
        a0 = a_strobes; b0 = b_strobes; s0 = n_start; r0 = n_mreset;
        run_load(0, 1'b0, 1'b0, 128);
        check("a_strobe_count", a_strobes - a0, 64);
        check("b_strobe_count", b_strobes - b0, 64);
        check("start_count", n_start - s0, 1);
        check("mreset_count", n_mreset - r0, 1);
        finish_wait(48, n_lc);

        // Same stream with in_valid low every other cycle; mult_done still high entering it.
        a0 = a_strobes; b0 = b_strobes;
        run_load(0, 1'b1, 1'b0, 128);
        check("gap_a_strobe_count", a_strobes - a0, 64);
        check("gap_b_strobe_count", b_strobes - b0, 64);
        finish_wait(5, n_lc);

        // Abort with reset 6 elements into B.
        s0 = n_start;
        run_load(0, 1'b0, 1'b0, 70);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("abort_reset");
        repeat (10) tick();
        check("abort_no_start", n_start - s0, 0);
        check("abort_sb_empty", sb.size(), 0);

        // Fresh load with ignored mult_done in LOAD_A and load_req in LOAD_B.
        s0 = n_start; r0 = n_mreset; l0 = n_lc;
        run_load(0, 1'b0, 1'b1, 128);
        check("poke_start_count", n_start - s0, 1);
        check("poke_mreset_count", n_mreset - r0, 1);
        check("poke_no_complete", n_lc - l0, 0);
        finish_wait(3, n_lc);

        // Sign extremes: A all -128, B all 127.
        run_load(1, 1'b0, 1'b0, 128);
        finish_wait(2, n_lc);

        repeat (3) tick();
        check("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
